// File: rtl/cover_toggle_collector.sv
// Toggle-coverage collector: sticky covered bitmap, each new point reported once on a valid/ready stream.
// Optional macro COVER_COLLECTOR_COUNT_EN adds a registered covered_count output.
module cover_toggle_collector #(
  parameter int                 WIDTH       = 65,
  parameter int                 INDEX_W     = 64,
  parameter logic [INDEX_W-1:0] COVER_INDEX = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [WIDTH-1:0]   valid,
  input  logic               clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic               all_covered
`ifdef COVER_COLLECTOR_COUNT_EN
  ,
  output logic [$clog2(WIDTH+1)-1:0] covered_count
`endif
);

  localparam int POS_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   r_covered;
  logic [WIDTH-1:0]   r_pending;
  logic               r_out_valid;
  logic [INDEX_W-1:0] r_out_index;
  logic               r_all_covered;

  logic [WIDTH-1:0]   w_new;
  logic [WIDTH-1:0]   w_sel_mask;
  logic [WIDTH-1:0]   w_pending_nxt;
  logic [POS_W-1:0]   w_sel_pos;
  logic               w_found;
  logic               w_load;

  assign w_new  = enable ? (valid & ~r_covered) : '0;
  assign w_load = !r_out_valid || out_ready;

  // Lowest set bit of registered pending wins; scanning downward leaves the lowest hit last.
  always_comb begin
    w_found    = 1'b0;
    w_sel_pos  = '0;
    w_sel_mask = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_found       = 1'b1;
        w_sel_pos     = POS_W'(i);
        w_sel_mask    = '0;
        w_sel_mask[i] = 1'b1;
      end
    end
  end

  // Pending bits are always already covered, so new bits never collide with the bit being retired.
  assign w_pending_nxt = (r_pending & ~(w_load ? w_sel_mask : '0)) | w_new;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_covered     <= '0;
      r_pending     <= '0;
      r_out_valid   <= 1'b0;
      r_out_index   <= '0;
      r_all_covered <= 1'b0;
    end else if (clear) begin
      r_covered     <= '0;
      r_pending     <= '0;
      r_out_valid   <= 1'b0;
      r_all_covered <= 1'b0;
    end else begin
      r_covered     <= r_covered | w_new;
      r_pending     <= w_pending_nxt;
      r_all_covered <= r_all_covered | (&r_covered);
      if (w_load) begin
        r_out_valid <= w_found;
        if (w_found) begin
          r_out_index <= COVER_INDEX + INDEX_W'(w_sel_pos);
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_index   = r_out_index;
  assign all_covered = r_all_covered;

`ifdef COVER_COLLECTOR_COUNT_EN
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_new_ones;

  assign w_new_ones = CNT_W'($countones(w_new));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + w_new_ones;
    end
  end

  assign covered_count = r_count;
`endif

endmodule

// File: tb/tb_cover_toggle_collector.sv
// Directed bench for cover_toggle_collector with WIDTH=65, COVER_INDEX=100.
module tb_cover_toggle_collector;

  localparam int WIDTH   = 65;
  localparam int INDEX_W = 64;

  logic               clock;
  logic               reset;
  logic               enable;
  logic [WIDTH-1:0]   valid;
  logic               clear;
  logic               out_valid;
  logic               out_ready;
  logic [INDEX_W-1:0] out_index;
  logic               all_covered;
`ifdef COVER_COLLECTOR_COUNT_EN
  logic [$clog2(WIDTH+1)-1:0] covered_count;
`endif

  int evals = 0;
  int fails = 0;
  int hs    = 0;
  int hs_start;

  cover_toggle_collector #(
    .WIDTH      (WIDTH),
    .INDEX_W    (INDEX_W),
    .COVER_INDEX(64'd100)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .enable     (enable),
    .valid      (valid),
    .clear      (clear),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .all_covered(all_covered)
`ifdef COVER_COLLECTOR_COUNT_EN
    ,
    .covered_count(covered_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (reset && out_valid && out_ready && !clear) hs++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    evals++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic put_bits(input int a, input int b, input int c);
    valid    = '0;
    valid[a] = 1'b1;
    valid[b] = 1'b1;
    valid[c] = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    enable    = 1'b0;
    valid     = '0;
    clear     = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_index", out_index, 0);
    chk("reset_all_covered", all_covered, 0);
    reset = 1'b1;
    enable = 1'b1;
    out_ready = 1'b1;

    // Idle with enable high.
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_all_covered", all_covered, 0);
    end

    // Single point: bit 3 -> index 103 two edges later, exactly once.
    valid = '0; valid[3] = 1'b1;
    tick();
    chk("b3_n1_out_valid", out_valid, 0);
    valid = '0;
    tick();
    chk("b3_n2_out_valid", out_valid, 1);
    chk("b3_n2_out_index", out_index, 103);
    tick();
    chk("b3_n3_out_valid", out_valid, 0);
    valid[3] = 1'b1;
    tick();
    valid = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("b3_repulse_out_valid", out_valid, 0);
    end

    // Disabled sampling ignores valid.
    enable = 1'b0;
    valid = '0; valid[9] = 1'b1;
    tick();
    valid = '0;
    tick();
    tick();
    chk("disabled_out_valid", out_valid, 0);
    enable = 1'b1;

    // Three bits in one cycle, consumer ready.
    put_bits(0, 5, 64);
    tick();
    valid = '0;
    tick();
    chk("b2b_r0_valid", out_valid, 1);
    chk("b2b_r0_index", out_index, 100);
    tick();
    chk("b2b_r1_valid", out_valid, 1);
    chk("b2b_r1_index", out_index, 105);
    tick();
    chk("b2b_r2_valid", out_valid, 1);
    chk("b2b_r2_index", out_index, 164);
    tick();
    chk("b2b_done_valid", out_valid, 0);

    // Bit 9 was never recorded while disabled.
    valid = '0; valid[9] = 1'b1;
    tick();
    valid = '0;
    tick();
    chk("b9_out_valid", out_valid, 1);
    chk("b9_out_index", out_index, 109);
    tick();

    // Same three bits under backpressure.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr1_out_valid", out_valid, 0);
    out_ready = 1'b0;
    put_bits(0, 5, 64);
    tick();
    valid = '0;
    tick();
    chk("bp_first_valid", out_valid, 1);
    chk("bp_first_index", out_index, 100);
    hs_start = hs;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_index", out_index, 100);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_r1_index", out_index, 105);
    tick();
    chk("bp_r2_index", out_index, 164);
    chk("bp_r2_valid", out_valid, 1);
    tick();
    chk("bp_done_valid", out_valid, 0);
    tick();
    chk("bp_handshakes", 64'(hs - hs_start), 3);

    // All 65 bits in one cycle.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    valid = '1;
    tick();
    valid = '0;
    chk("all_e0_all_covered", all_covered, 0);
    tick();
    chk("all_e1_all_covered", all_covered, 1);
`ifdef COVER_COLLECTOR_COUNT_EN
    chk("all_covered_count", covered_count, 65);
`endif
    chk("all_r0_index", out_index, 100);
    for (int k = 1; k < 65; k++) begin
      tick();
      chk("all_drain_valid", out_valid, 1);
      chk("all_drain_index", out_index, 64'(100 + k));
    end
    tick();
    chk("all_drain_end_valid", out_valid, 0);
    chk("all_sticky", all_covered, 1);

    // Clear with a report outstanding and more pending; bit 7 in the same cycle is dropped.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    put_bits(0, 5, 64);
    tick();
    valid = '0;
    out_ready = 1'b0;
    tick();
    chk("clr_pre_valid", out_valid, 1);
    clear = 1'b1;
    valid = '0; valid[7] = 1'b1;
    tick();
    clear = 1'b0;
    valid = '0;
    out_ready = 1'b1;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_all_covered", all_covered, 0);
    tick();
    tick();
    chk("clr_no_leftover", out_valid, 0);
    valid[7] = 1'b1;
    tick();
    valid = '0;
    tick();
    chk("b7_out_valid", out_valid, 1);
    chk("b7_out_index", out_index, 107);
    tick();
    chk("b7_done_valid", out_valid, 0);

    // Asynchronous reset drops a held report without a clock edge.
    valid[20] = 1'b1;
    out_ready = 1'b0;
    tick();
    valid = '0;
    tick();
    chk("ar_pre_valid", out_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_index", out_index, 0);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("ar_after_valid", out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end

endmodule
